// File: rtl/turn_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | turn_ctl: shooting-phase sequencer for the two-player ships game.         |
// | Optional answer timeout/resend logic: define TURN_TIMEOUT_RETRY_EN.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module turn_ctl #(
  parameter int SHIP_CELLS  = 20,
  parameter int TIMEOUT_CYC = 65_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       set_player,
  input  logic       shot_valid,
  input  logic [7:0] shot_pos,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       board_query_valid,
  output logic [7:0] board_query_pos,
  input  logic       board_ans_valid,
  input  logic       board_hit,
  output logic       your_turn,
  output logic       result_valid,
  output logic       result_hit,
  output logic       game_over,
  output logic       game_won,
  output logic       link_error
);

  localparam int               CNT_W       = $clog2(SHIP_CELLS + 1);
  localparam logic [CNT_W-1:0] c_SHIP_MAX  = CNT_W'(SHIP_CELLS);
  localparam logic [CNT_W-1:0] c_SHIP_LAST = CNT_W'(SHIP_CELLS - 1);
  localparam logic [7:0]       c_ANS_HIT   = 8'hA1;
  localparam logic [7:0]       c_ANS_MISS  = 8'hA0;

  typedef enum logic [3:0] {
    S_IDLE, S_MY_TURN, S_SEND_SHOT, S_WAIT_ANS, S_THEIR_TURN,
    S_QUERY, S_SEND_ANS, S_RESEND, S_GAME_OVER
  } state_t;

  state_t r_state, w_state_nxt, r_ret_state;

  logic [7:0]       r_shot, r_tx_data, r_query_pos, w_tx_byte;
  logic             r_tx_start, r_result_valid, r_result_hit, r_query_valid;
  logic             r_ans_hit, r_ans_done, r_game_won;
  logic [CNT_W-1:0] r_hit_cnt, r_taken_cnt;
  logic             w_dup, w_tx_go, w_latch_shot, w_res_hit, w_res_miss, w_query;
  logic             w_ans_latch, w_dup_go, w_win, w_taken_inc;
  logic             w_timeout, w_retry_left, w_retry_inc, w_link_fail;

  function automatic logic coord_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  // Opponent resending the position we last answered: our answer was lost.
  assign w_dup = r_ans_done && rx_valid && (rx_data == r_query_pos);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tx_go      = 1'b0;
    w_tx_byte    = r_ans_hit ? c_ANS_HIT : c_ANS_MISS;
    w_latch_shot = 1'b0;
    w_res_hit    = 1'b0;
    w_res_miss   = 1'b0;
    w_query      = 1'b0;
    w_ans_latch  = 1'b0;
    w_dup_go     = 1'b0;
    w_win        = 1'b0;
    w_taken_inc  = 1'b0;
    w_retry_inc  = 1'b0;
    w_link_fail  = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = set_player ? S_MY_TURN : S_THEIR_TURN;
      S_MY_TURN: begin
        if (w_dup) begin
          w_dup_go    = 1'b1;
          w_state_nxt = S_RESEND;
        end else if (shot_valid && coord_ok(shot_pos)) begin
          w_latch_shot = 1'b1;
          w_state_nxt  = S_SEND_SHOT;
        end
      end
      S_SEND_SHOT: begin
        w_tx_byte = r_shot;
        if (!tx_busy) begin
          w_tx_go     = 1'b1;
          w_state_nxt = S_WAIT_ANS;
        end
      end
      S_WAIT_ANS: begin
        if (rx_valid && rx_data == c_ANS_HIT) begin
          w_res_hit = 1'b1;
          if (r_hit_cnt >= c_SHIP_LAST) begin
            w_win       = 1'b1;
            w_state_nxt = S_GAME_OVER;
          end else begin
            w_state_nxt = S_MY_TURN;
          end
        end else if (rx_valid && rx_data == c_ANS_MISS) begin
          w_res_miss  = 1'b1;
          w_state_nxt = S_THEIR_TURN;
        end else if (w_timeout) begin
          if (w_retry_left) begin
            w_retry_inc = 1'b1;
            w_state_nxt = S_SEND_SHOT;
          end else begin
            w_link_fail = 1'b1;
            w_state_nxt = S_GAME_OVER;
          end
        end
      end
      S_THEIR_TURN: begin
        if (w_dup) begin
          w_dup_go    = 1'b1;
          w_state_nxt = S_RESEND;
        end else if (rx_valid && coord_ok(rx_data)) begin
          w_query     = 1'b1;
          w_state_nxt = S_QUERY;
        end
      end
      S_QUERY: begin
        if (board_ans_valid) begin
          w_ans_latch = 1'b1;
          w_state_nxt = S_SEND_ANS;
        end
      end
      S_SEND_ANS: begin
        if (!tx_busy) begin
          w_tx_go = 1'b1;
          if (!r_ans_hit) begin
            w_state_nxt = S_MY_TURN;
          end else begin
            w_taken_inc = 1'b1;
            w_state_nxt = (r_taken_cnt >= c_SHIP_LAST) ? S_GAME_OVER : S_THEIR_TURN;
          end
        end
      end
      S_RESEND: begin
        if (!tx_busy) begin
          w_tx_go     = 1'b1;
          w_state_nxt = r_ret_state;
        end
      end
      S_GAME_OVER: w_state_nxt = S_GAME_OVER;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shot         <= 8'h00;
      r_tx_data      <= 8'h00;
      r_tx_start     <= 1'b0;
      r_result_valid <= 1'b0;
      r_result_hit   <= 1'b0;
      r_query_valid  <= 1'b0;
      r_query_pos    <= 8'h00;
      r_ans_hit      <= 1'b0;
      r_ans_done     <= 1'b0;
      r_game_won     <= 1'b0;
      r_hit_cnt      <= '0;
      r_taken_cnt    <= '0;
      r_ret_state    <= S_IDLE;
    end else begin
      r_tx_start     <= w_tx_go;
      r_result_valid <= w_res_hit | w_res_miss;
      r_query_valid  <= w_query;
      if (w_tx_go)                 r_tx_data    <= w_tx_byte;
      if (w_res_hit | w_res_miss)  r_result_hit <= w_res_hit;
      if (w_query)                 r_query_pos  <= rx_data;
      if (w_latch_shot)            r_shot       <= shot_pos;
      if (w_ans_latch)             r_ans_hit    <= board_hit;
      if (w_dup_go)                r_ret_state  <= r_state;
      if (w_win)                   r_game_won   <= 1'b1;
      if (r_state == S_SEND_ANS && w_tx_go) r_ans_done <= 1'b1;
      if (w_res_hit && r_hit_cnt != c_SHIP_MAX)     r_hit_cnt   <= r_hit_cnt + 1'b1;
      if (w_taken_inc && r_taken_cnt != c_SHIP_MAX) r_taken_cnt <= r_taken_cnt + 1'b1;
    end
  end

`ifdef TURN_TIMEOUT_RETRY_EN
  localparam int               TMR_W     = $clog2(TIMEOUT_CYC + 1);
  localparam int               RTY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [TMR_W-1:0] c_TMR_MAX = TMR_W'(TIMEOUT_CYC);
  localparam logic [RTY_W-1:0] c_RTY_MAX = RTY_W'(MAX_RETRY);

  logic [TMR_W-1:0] r_timer;
  logic [RTY_W-1:0] r_retry;
  logic             r_link_error;

  assign w_timeout    = (r_timer == c_TMR_MAX);
  assign w_retry_left = (r_retry < c_RTY_MAX);
  assign link_error   = r_link_error;

  // Timer runs only while an answer is outstanding; any other state clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer      <= '0;
      r_retry      <= '0;
      r_link_error <= 1'b0;
    end else begin
      r_timer <= (r_state == S_WAIT_ANS && !w_timeout) ? r_timer + 1'b1 : '0;
      if (w_res_hit | w_res_miss) r_retry <= '0;
      else if (w_retry_inc)       r_retry <= r_retry + 1'b1;
      if (w_link_fail)            r_link_error <= 1'b1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_timeout    = 1'b0;
  assign w_retry_left = 1'b0;
  assign link_error   = 1'b0;
  assign w_unused_cfg = w_retry_inc ^ w_link_fail ^ (TIMEOUT_CYC > 0) ^ (MAX_RETRY > 0);
`endif

  assign tx_data           = r_tx_data;
  assign tx_start          = r_tx_start;
  assign board_query_valid = r_query_valid;
  assign board_query_pos   = r_query_pos;
  assign your_turn         = (r_state == S_MY_TURN);
  assign result_valid      = r_result_valid;
  assign result_hit        = r_result_hit;
  assign game_over         = (r_state == S_GAME_OVER);
  assign game_won          = r_game_won;

endmodule
`default_nettype wire

// File: tb/tb_turn_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_turn_ctl: vector-table bench for turn_ctl plus reset/timeout sequences.|
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_turn_ctl;
  localparam int SHIP_CELLS  = 2;
  localparam int TIMEOUT_CYC = 100;
  localparam int MAX_RETRY   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, set_player = 1'b0, shot_valid = 1'b0, tx_busy = 1'b0;
  logic       rx_valid = 1'b0, board_ans_valid = 1'b0, board_hit = 1'b0;
  logic [7:0] shot_pos = 8'h00, rx_data = 8'h00;
  logic [7:0] tx_data, board_query_pos;
  logic       tx_start, board_query_valid, your_turn, result_valid, result_hit;
  logic       game_over, game_won, link_error;

  always #5 clk = ~clk;

  turn_ctl #(.SHIP_CELLS(SHIP_CELLS), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .start(start), .set_player(set_player),
    .shot_valid(shot_valid), .shot_pos(shot_pos), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data),
    .board_query_valid(board_query_valid), .board_query_pos(board_query_pos),
    .board_ans_valid(board_ans_valid), .board_hit(board_hit), .your_turn(your_turn),
    .result_valid(result_valid), .result_hit(result_hit), .game_over(game_over),
    .game_won(game_won), .link_error(link_error)
  );

  // {tx_start, tx_data, your_turn, result_valid, result_hit, query_valid, query_pos, over, won, link}
  logic [23:0] outs;
  assign outs = {tx_start, tx_data, your_turn, result_valid, result_hit, board_query_valid,
                 board_query_pos, game_over, game_won, link_error};

  typedef enum logic [2:0] {OP_NONE, OP_RST, OP_START, OP_SHOT, OP_RX, OP_ANS} op_e;
  typedef struct {
    op_e         op;
    logic [7:0]  arg;
    logic        busy;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   n;
  logic seen;

  function automatic void add(input op_e op, input logic [7:0] arg, input logic busy,
                              input logic ts, input logic [7:0] td, input logic yt,
                              input logic rv, input logic rh, input logic qv,
                              input logic [7:0] qp, input logic go, input logic gw);
    vec_t v;
    v.op   = op;
    v.arg  = arg;
    v.busy = busy;
    v.exp  = {ts, td, yt, rv, rh, qv, qp, go, gw, 1'b0};
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    start = 1'b0; set_player = 1'b0; shot_valid = 1'b0; shot_pos = 8'h00; tx_busy = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; board_ans_valid = 1'b0; board_hit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Local player starts: invalid clicks, shot 34, miss, then answer opponent.
    add(OP_RST,   8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_START, 8'h01, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
    add(OP_SHOT,  8'hA3, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
    add(OP_SHOT,  8'h3C, 0, 0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0);
    add(OP_SHOT,  8'h34, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_NONE,  8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'h34, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'h34, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_RX,    8'hA0, 0, 0, 8'h34, 0, 1, 0, 0, 8'h00, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'h34, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_RX,    8'h59, 0, 0, 8'h34, 0, 0, 0, 1, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'h34, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'h34, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_ANS,   8'h01, 0, 0, 8'h34, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_RX,    8'h59, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_RX,    8'h12, 0, 0, 8'hA1, 0, 0, 0, 1, 8'h12, 0, 0);
    add(OP_ANS,   8'h00, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h12, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA0, 1, 0, 0, 0, 8'h12, 0, 0);
    add(OP_RX,    8'h12, 0, 0, 8'hA0, 0, 0, 0, 0, 8'h12, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA0, 1, 0, 0, 0, 8'h12, 0, 0);
    // Two hits with SHIP_CELLS = 2 win the game; later inputs are ignored.
    add(OP_SHOT,  8'h45, 0, 0, 8'hA0, 0, 0, 0, 0, 8'h12, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'h45, 0, 0, 0, 0, 8'h12, 0, 0);
    add(OP_RX,    8'h77, 0, 0, 8'h45, 0, 0, 0, 0, 8'h12, 0, 0);
    add(OP_RX,    8'hA1, 0, 0, 8'h45, 1, 1, 1, 0, 8'h12, 0, 0);
    add(OP_SHOT,  8'h99, 0, 0, 8'h45, 0, 0, 1, 0, 8'h12, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'h99, 0, 0, 1, 0, 8'h12, 0, 0);
    add(OP_RX,    8'hA1, 0, 0, 8'h99, 0, 1, 1, 0, 8'h12, 1, 1);
    add(OP_SHOT,  8'h22, 0, 0, 8'h99, 0, 0, 1, 0, 8'h12, 1, 1);
    add(OP_RX,    8'h33, 0, 0, 8'h99, 0, 0, 1, 0, 8'h12, 1, 1);
    add(OP_RX,    8'h12, 0, 0, 8'h99, 0, 0, 1, 0, 8'h12, 1, 1);
    add(OP_START, 8'h01, 0, 0, 8'h99, 0, 0, 1, 0, 8'h12, 1, 1);
    // Opponent starts and sinks both cells, with a duplicate in between.
    add(OP_RST,   8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_START, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_RX,    8'h3A, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_SHOT,  8'h34, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_RX,    8'h59, 0, 0, 8'h00, 0, 0, 0, 1, 8'h59, 0, 0);
    add(OP_ANS,   8'h01, 0, 0, 8'h00, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_RX,    8'h59, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA1, 0, 0, 0, 0, 8'h59, 0, 0);
    add(OP_RX,    8'h00, 0, 0, 8'hA1, 0, 0, 0, 1, 8'h00, 0, 0);
    add(OP_ANS,   8'h01, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h00, 0, 0);
    add(OP_NONE,  8'h00, 0, 1, 8'hA1, 0, 0, 0, 0, 8'h00, 1, 0);
    add(OP_SHOT,  8'h11, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h00, 1, 0);
    add(OP_RX,    8'h45, 0, 0, 8'hA1, 0, 0, 0, 0, 8'h00, 1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst             = (vecs[i].op == OP_RST);
      start           = (vecs[i].op == OP_START);
      set_player      = (vecs[i].op == OP_START) && vecs[i].arg[0];
      shot_valid      = (vecs[i].op == OP_SHOT);
      shot_pos        = (vecs[i].op == OP_SHOT) ? vecs[i].arg : 8'h00;
      tx_busy         = vecs[i].busy;
      rx_valid        = (vecs[i].op == OP_RX);
      rx_data         = (vecs[i].op == OP_RX) ? vecs[i].arg : 8'h00;
      board_ans_valid = (vecs[i].op == OP_ANS);
      board_hit       = (vecs[i].op == OP_ANS) && vecs[i].arg[0];
      tick();
      chk($sformatf("vec%0d", i), {8'h00, outs}, {8'h00, vecs[i].exp});
    end

    // Asynchronous reset while a shot transmission is being requested.
    @(negedge clk); clr_in(); rst = 1'b1;
    tick();
    @(negedge clk); rst = 1'b0; start = 1'b1; set_player = 1'b1;
    tick();
    @(negedge clk); start = 1'b0; shot_valid = 1'b1; shot_pos = 8'h34;
    tick();
    @(negedge clk); shot_valid = 1'b0;
    tick();
    chk("tx_before_rst", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'h34});
    #2 rst = 1'b1;
    #1 chk("async_rst_outs", {8'h00, outs}, 32'h0);
    @(negedge clk); rst = 1'b0; rx_valid = 1'b1; rx_data = 8'hA0;
    tick();
    chk("idle_ignores_rx", {8'h00, outs}, 32'h0);

    // Unanswered shot: resend behaviour depends on the timeout option.
    @(negedge clk); clr_in(); start = 1'b1; set_player = 1'b1;
    tick();
    @(negedge clk); start = 1'b0; shot_valid = 1'b1; shot_pos = 8'h34;
    tick();
    @(negedge clk); shot_valid = 1'b0;
    tick();
    chk("first_send", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'h34});
`ifdef TURN_TIMEOUT_RETRY_EN
    for (int r = 1; r <= MAX_RETRY; r++) begin
      n = 1;
      tick();
      while (!tx_start && n < 3 * TIMEOUT_CYC) begin
        tick();
        n++;
      end
      chk($sformatf("retry%0d_byte", r), {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'h34});
      n_checks++;
      if (n < TIMEOUT_CYC || n > TIMEOUT_CYC + 10) begin
        n_err++;
        $display("FAIL retry%0d_gap: got %0d cycles expected %0d..%0d", r, n,
                 TIMEOUT_CYC, TIMEOUT_CYC + 10);
      end
      chk($sformatf("retry%0d_link", r), {31'd0, link_error}, 32'd0);
    end
    n = 1;
    seen = 1'b0;
    tick();
    while (!game_over && n < 3 * TIMEOUT_CYC) begin
      if (tx_start) seen = 1'b1;
      tick();
      n++;
    end
    chk("link_error_end", {28'd0, game_over, game_won, link_error, seen},
        {28'd0, 1'b1, 1'b0, 1'b1, 1'b0});
`else
    seen = 1'b0;
    for (int k = 0; k < 3 * TIMEOUT_CYC + 10; k++) begin
      tick();
      if (tx_start || link_error || game_over || your_turn) seen = 1'b1;
    end
    chk("no_timeout", {31'd0, seen}, 32'd0);
    @(negedge clk); rx_valid = 1'b1; rx_data = 8'hA0;
    tick();
    chk("late_answer", {29'd0, result_valid, result_hit, link_error}, {29'd0, 1'b1, 1'b0, 1'b0});
`endif
    @(negedge clk); clr_in();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/turn_ctl.md
Name: turn_ctl

Overview:
- Sequences the two-player shooting phase of the ships game after both boards are placed.
- Sends the local shot position to the opponent over the UART link and waits for the hit/miss answer byte.
- Answers the opponent's incoming shots by querying the local board.
- Counts hits and sunk cells, and decides turn ownership and end of game.
- Sits between the mouse/board logic and the UART tx/rx wrappers; the drawing blocks consume its status outputs.

Parameters:
SHIP_CELLS, 20, total occupied cells per board; reaching it ends the game
TIMEOUT_CYC, 65_000_000, cycles to wait for an answer byte before resending (1 s at 65 MHz)
MAX_RETRY, 3, resends allowed before declaring link error

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle pulse: both boards placed, shooting phase begins
set_player  in  1  sampled at start; 1 = local player shoots first
shot_valid  in  1  one-cycle pulse: local player clicked an opponent cell
shot_pos  in  8  {row[7:4], col[3:0]}, valid range 0..9 each
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle transmit request
tx_busy  in  1  UART transmitter busy
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte
rx_data  in  8  received byte
board_query_valid  out  1  one-cycle pulse: look up board_query_pos on the own board
board_query_pos  out  8  {row, col} of the opponent's shot
board_ans_valid  in  1  one-cycle pulse: board_hit is valid (any latency >= 1)
board_hit  in  1  1 = queried own cell holds a ship
your_turn  out  1  local player may shoot
result_valid  out  1  one-cycle pulse: answer to the local shot received
result_hit  out  1  1 = last local shot hit; held until the next result
game_over  out  1  game finished; sticky
game_won  out  1  valid while game_over; 1 = local player won
link_error  out  1  retries exhausted; sticky

Behaviour:
- Reset values:
  - All outputs are 0, tx_data is 0, board_query_pos is 0.
  - Counters are cleared and state is IDLE.
  - Reset asserted mid-operation aborts everything immediately, including any pending tx.
- Protocol bytes:
  - Shot byte = {row, col}.
  - Answer bytes: 8'hA1 = hit, 8'hA0 = miss.
  - A coordinate is valid only if row <= 9 and col <= 9.
- States:
  - IDLE: on start, go to MY_TURN if set_player = 1, else THEIR_TURN.
  - MY_TURN: your_turn = 1.
    - shot_valid with a valid coordinate latches shot_pos and goes to SEND_SHOT.
    - Invalid coordinates are ignored.
  - SEND_SHOT: while tx_busy = 1, wait.
    - On the first cycle with tx_busy = 0, pulse tx_start for one cycle with tx_data = latched shot.
    - Then go to WAIT_ANS with the timer cleared.
  - WAIT_ANS:
    - rx 8'hA1: result_valid pulse, result_hit = 1, hit_cnt++. If hit_cnt reaches SHIP_CELLS, go to GAME_OVER with game_won = 1. Otherwise go to MY_TURN (a hit keeps the turn).
    - rx 8'hA0: result_valid pulse, result_hit = 0, go to THEIR_TURN.
    - Any other byte is ignored.
  - THEIR_TURN:
    - rx_valid with a valid coordinate byte latches board_query_pos, pulses board_query_valid in the next cycle, and goes to QUERY.
    - Invalid bytes are ignored.
  - QUERY: wait for board_ans_valid; latch board_hit, then go to SEND_ANS.
  - SEND_ANS: same tx handshake as SEND_SHOT, with tx_data = 8'hA1 or 8'hA0.
    - Hit: taken_cnt++. If taken_cnt reaches SHIP_CELLS, go to GAME_OVER with game_won = 0. Otherwise return to THEIR_TURN.
    - Miss: go to MY_TURN.
  - GAME_OVER: game_over = 1 and your_turn = 0; hold until rst. All rx bytes and shot_valid are ignored.
- Duplicate shot:
  - In MY_TURN or THEIR_TURN, a received shot byte equal to the last answered position (the opponent is resending after its own timeout) re-sends the stored answer.
  - This does not change taken_cnt, the turn, or the state afterwards.
- Counter widths:
  - hit_cnt and taken_cnt are $clog2(SHIP_CELLS+1) bits and saturate at SHIP_CELLS.
  - The timer is $clog2(TIMEOUT_CYC+1) bits.
- Simultaneity:
  - shot_valid is ignored outside MY_TURN.
  - rx_valid and tx handshakes in the same cycle are independent; rx is processed per state rules.

Optional Feature:
TURN_TIMEOUT_RETRY_EN
- Defined:
  - In WAIT_ANS, the timer counts each cycle.
  - At TIMEOUT_CYC with no answer: if retry_cnt < MAX_RETRY, increment retry_cnt and return to SEND_SHOT (same byte).
  - Otherwise set link_error = 1 and go to GAME_OVER with game_won = 0.
  - retry_cnt clears on every accepted answer.
- Undefined: WAIT_ANS waits indefinitely; link_error is tied to 0; no timer or retry logic is synthesized.

Test Plan:
1. rst, then start with set_player = 1, shot_valid with shot_pos = 8'h34 -> your_turn = 1 before the click; one tx_start with tx_data = 8'h34 once tx_busy = 0; rx 8'hA0 -> result_valid with result_hit = 0, your_turn = 0.
2. start with set_player = 0, rx 8'h59, board_hit = 1 after 3 cycles -> board_query_pos = 8'h59; tx_data = 8'hA1; stays THEIR_TURN. Then rx 8'h12 with board_hit = 0 -> tx 8'hA0; your_turn = 1.
3. shot_valid with shot_pos = 8'hA3 or 8'h3C in MY_TURN -> no tx_start, state unchanged.
4. SHIP_CELLS = 2: two shots answered 8'hA1 -> game_over = 1, game_won = 1. Later shot_valid or rx is ignored.
5. After answering shot 8'h59, rx 8'h59 again -> tx 8'hA1 re-sent, taken_cnt unchanged, state unchanged.
6. With TURN_TIMEOUT_RETRY_EN, TIMEOUT_CYC = 100, no answer -> tx of the same byte at about 100, 200 and 300 cycles after the first send; link_error = 1 and game_over = 1 after the 4th timeout. Also assert rst mid-WAIT_ANS -> all outputs return to 0 without waiting for a clock edge.
